// File: rtl/polar_fg_sched.sv
// polar_fg_sched: stage scheduler for polar SC decoding.
// Takes one stage vector of 2*N LLRs and computes N node outputs (min-sum f,
// or g when compiled in). The work is spread over P lanes for N/P beats.
// Optional g lanes: define POLAR_FG_SCHED_G_EN to compile them in. When it is
// undefined, only f lanes exist and mode/u_in are ignored.
module polar_fg_sched #(
  parameter int BITS = 4,
  parameter int N    = 16,
  parameter int P    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [2*N*BITS-1:0]    llr_in,
  input  logic [N-1:0]           u_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*BITS-1:0]      llr_out
);

  localparam int BEATS = N / P;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BITS-2:0]        MAG_ONE = (BITS-1)'(1);
  localparam logic signed [BITS:0]   G_MAX   = (BITS+1)'((2 ** (BITS-1)) - 1);
  localparam logic signed [BITS:0]   G_MIN   = -G_MAX;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [2*N*BITS-1:0] llr_q;
  logic [N*BITS-1:0]   out_q;
  logic [P*BITS-1:0]   lane_res;
  logic                last_beat;
  logic                accept;

  assign last_beat = (k_q == KW'(BEATS - 1));
  assign accept    = (state_q == IDLE) && in_valid;

  // Min-sum f, bit-exact with the legacy f unit. The magnitude keeps only the
  // low BITS-1 bits, so the most-negative code has magnitude 0, and a zero
  // magnitude with a negative sign encodes as 1 followed by zeros.
  function automatic logic [BITS-1:0] f_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    logic [BITS-1:0] na, nb;
    logic [BITS-2:0] ma, mb, m, nm;
    logic            s;
    na = -a;
    nb = -b;
    ma = a[BITS-1] ? na[BITS-2:0] : a[BITS-2:0];
    mb = b[BITS-1] ? nb[BITS-2:0] : b[BITS-2:0];
    m  = (ma < mb) ? ma : mb;
    nm = ~m + MAG_ONE;
    s  = a[BITS-1] ^ b[BITS-1];
    return {s, (s ? nm : m)};
  endfunction

`ifdef POLAR_FG_SCHED_G_EN
  // g: b + a or b - a in one extra bit, saturated symmetrically.
  function automatic logic [BITS-1:0] g_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                          input logic u);
    logic signed [BITS:0] ax, bx, sum;
    ax  = {a[BITS-1], a};
    bx  = {b[BITS-1], b};
    sum = u ? (bx - ax) : (bx + ax);
    if (sum > G_MAX) begin
      sum = G_MAX;
    end else if (sum < G_MIN) begin
      sum = G_MIN;
    end
    return sum[BITS-1:0];
  endfunction
`endif

  // State and beat counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state and beat counter sequencing
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        k_d = '0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_beat) begin
          state_d = HOLD;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
  end

  // Capture the stage vector on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      llr_q <= '0;
    end else if (accept) begin
      llr_q <= llr_in;
    end
  end

`ifdef POLAR_FG_SCHED_G_EN
  logic         mode_q;
  logic [N-1:0] u_q;

  // Capture g controls on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      u_q    <= '0;
    end else if (accept) begin
      mode_q <= mode;
      u_q    <= u_in;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{mode, u_in};
`endif

  // Lane gi handles node index k*P + gi on every RUN beat
  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    logic [BITS-1:0] a_l, b_l;
    assign a_l = llr_q[(int'(k_q) * P + gi) * BITS +: BITS];
    assign b_l = llr_q[(N + int'(k_q) * P + gi) * BITS +: BITS];
`ifdef POLAR_FG_SCHED_G_EN
    logic u_l;
    assign u_l = u_q[int'(k_q) * P + gi];
    assign lane_res[gi*BITS +: BITS] = mode_q ? g_op(a_l, b_l, u_l) : f_op(a_l, b_l);
`else
    assign lane_res[gi*BITS +: BITS] = f_op(a_l, b_l);
`endif
  end

  // Output register: slot i is written on the beat where k == i/P and keeps
  // its value otherwise, so the last result survives until the next RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (k_q == KW'(i / P)) begin
          out_q[i*BITS +: BITS] <= lane_res[(i % P)*BITS +: BITS];
        end
      end
    end
  end

  assign llr_out = out_q;

endmodule

// File: tb/tb_polar_fg_sched.sv
// Scoreboard bench for polar_fg_sched. Accepted vectors push their expected
// result (from an integer-arithmetic reference model); a monitor pops and
// compares whenever a result is handed over.
module tb_polar_fg_sched;

  localparam int BITS  = 4;
  localparam int N     = 16;
  localparam int P     = 4;
  localparam int BEATS = N / P;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic                mode;
  logic [2*N*BITS-1:0] llr_in;
  logic [N-1:0]        u_in;
  logic                out_valid;
  logic                out_ready;
  logic [N*BITS-1:0]   llr_out;

  polar_fg_sched #(.BITS(BITS), .N(N), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .llr_in    (llr_in),
    .u_in      (u_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .llr_out   (llr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*BITS-1:0] v;
    int                acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  int   checks = 0;
  bit   rand_ready = 1'b0;
  logic [2*N*BITS-1:0] sv;
  logic [N-1:0]        su;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic int sval(input logic [BITS-1:0] x);
    return x[BITS-1] ? (int'(x) - (1 << BITS)) : int'(x);
  endfunction

  function automatic logic [BITS-1:0] ref_f(input int a, input int b);
    int lo, ma, mb, m, r;
    lo = -(1 << (BITS-1));
    ma = (a == lo) ? 0 : ((a < 0) ? -a : a);
    mb = (b == lo) ? 0 : ((b < 0) ? -b : b);
    m  = (ma < mb) ? ma : mb;
    if ((a < 0) != (b < 0)) r = (m == 0) ? lo : -m;
    else                    r = m;
    return r[BITS-1:0];
  endfunction

  function automatic logic [BITS-1:0] ref_g(input int a, input int b, input logic u);
    int s, mx;
    mx = (1 << (BITS-1)) - 1;
    s  = u ? (b - a) : (b + a);
    if (s > mx)  s = mx;
    if (s < -mx) s = -mx;
    return s[BITS-1:0];
  endfunction

  function automatic logic [N*BITS-1:0] ref_vec(input logic [2*N*BITS-1:0] l,
                                                input logic [N-1:0] u, input logic m);
    logic [N*BITS-1:0] r;
    int a, b;
    r = '0;
    for (int i = 0; i < N; i++) begin
      a = sval(l[i*BITS +: BITS]);
      b = sval(l[(N+i)*BITS +: BITS]);
`ifdef POLAR_FG_SCHED_G_EN
      r[i*BITS +: BITS] = m ? ref_g(a, b, u[i]) : ref_f(a, b);
`else
      r[i*BITS +: BITS] = (m | ~m) ? ref_f(a, b) : ref_g(a, b, u[i]);
`endif
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [N*BITS-1:0] act, input logic [N*BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put(input int i, input int a, input int b);
    sv[i*BITS +: BITS]     = a[BITS-1:0];
    sv[(N+i)*BITS +: BITS] = b[BITS-1:0];
  endtask

  task automatic rand_vec();
    int x;
    for (int i = 0; i < 2*N; i++) begin
      x = $urandom_range(0, 15);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: x = 8;
          1: x = 0;
          2: x = 7;
          default: x = 9;
        endcase
      end
      sv[i*BITS +: BITS] = x[BITS-1:0];
    end
    su = N'($urandom);
  endtask

  task automatic send(input logic [2*N*BITS-1:0] l, input logic [N-1:0] u, input logic m);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    llr_in   = l;
    u_in     = u;
    mode     = m;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errs++;
      $display("FAIL accept_timeout: in_ready never seen");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errs++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (in_valid && in_ready) begin
          e.v   = ref_vec(llr_in, u_in, mode);
          e.acc = cyc + 1;
          sb.push_back(e);
          vecs++;
          $display("accept #%0d mode=%0b cycle=%0d", vecs, mode, cyc + 1);
        end
        // HOLD becomes visible after edge acc+BEATS, so the consumer sees
        // out_valid on edge acc+BEATS+1.
        if (out_valid && !prev && sb.size() > 0) begin
          chk("latency", N*BITS'(cyc - sb[0].acc), N*BITS'(BEATS));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            errs++;
            checks++;
            $display("FAIL unexpected_output: got %h expected none", llr_out);
          end else begin
            e = sb.pop_front();
            $display("result %h expected %h", llr_out, e.v);
            chk("result", llr_out, e.v);
          end
        end
        prev = out_valid;
      end else begin
        prev = 1'b0;
      end
    end
  end

  // Random back-pressure during the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N*BITS-1:0] held;
    bit ok;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    llr_in    = '0;
    u_in      = '0;
    out_ready = 1'b1;
    sv        = '0;
    su        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", N*BITS'(out_valid), '0);
    chk("reset_llr_out", llr_out, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", N*BITS'(in_ready), N*BITS'(1));
    @(posedge clk);
    #1;

    // f basic: 3 with -5 -> -3 in every slot
    for (int i = 0; i < N; i++) put(i, 3, -5);
    send(sv, '0, 1'b0);
    drain();

    // f corners
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: put(i, 0, -3);
        1: put(i, -8, 3);
        2: put(i, -8, -3);
        default: put(i, 7, 7);
      endcase
    end
    send(sv, '0, 1'b0);
    drain();

    // g saturation cases
    for (int i = 0; i < N; i++) begin
      case (i % 3)
        0: begin put(i, 5, 4);  su[i] = 1'b0; end
        1: begin put(i, 6, -4); su[i] = 1'b1; end
        default: begin put(i, 2, 5); su[i] = 1'b1; end
      endcase
    end
    send(sv, su, 1'b1);
    drain();

    // Slot ordering ramp
    for (int i = 0; i < N; i++) put(i, i % 8, 7);
    send(sv, '0, 1'b0);
    drain();

    // Back-pressure: hold the result for 10 cycles with a new vector waiting
    out_ready = 1'b0;
    rand_vec();
    send(sv, su, 1'b0);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errs++;
      $display("FAIL bp_valid_timeout: out_valid never seen");
    end
    held = llr_out;
    #1;
    rand_vec();
    in_valid = 1'b1;
    llr_in   = sv;
    u_in     = su;
    mode     = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", N*BITS'(in_ready), '0);
      chk("bp_hold", llr_out, held);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_next", N*BITS'(in_ready), N*BITS'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Reset in the middle of RUN aborts the vector
    rand_vec();
    send(sv, su, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_out_valid", N*BITS'(out_valid), '0);
    chk("abort_llr_out", llr_out, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", N*BITS'(in_ready), N*BITS'(1));
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_output", N*BITS'(out_valid), '0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      rand_vec();
      send(sv, su, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/polar_fg_sched.md
# polar_fg_sched

Stage scheduler for polar SC decoding. Accepts one stage vector of 2·N LLRs and computes N node outputs, either the min-sum f-function or the g-function. The work is time-multiplexed over P parallel lanes, each lane being an instance of the existing f unit (plus a g adder when enabled). The block sits between the LLR memory and the decoder tree controller, with a valid/ready handshake on both sides.

## Interface
- BITS, 4, LLR width in two's complement.
- N, 16, output LLRs per stage; must be a multiple of P.
- P, 4, number of parallel f/g lanes.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  stage vector valid.
- in_ready  out  1  block can accept a vector.
- mode  in  1  0 = f, 1 = g; sampled on accept.
- llr_in  in  2·N·BITS  a_i = llr_in[i·BITS +: BITS], b_i = llr_in[(N+i)·BITS +: BITS], for i in 0..N-1.
- u_in  in  N  partial-sum bits for g; u_i = u_in[i].
- out_valid  out  1  llr_out holds a complete result.
- out_ready  in  1  consumer accepts the result.
- llr_out  out  N·BITS  result i at llr_out[i·BITS +: BITS].

## Operation
- The FSM has three states: IDLE, RUN, HOLD.
- **IDLE**
  - in_ready = 1.
  - When in_valid is high, capture llr_in, u_in and mode into internal registers.
  - Clear the beat counter k.
  - Go to RUN.
- **RUN**
  - in_ready = 0.
  - Each cycle, lane j (0..P-1) processes index i = k·P + j and writes its result into the llr_out register at slot i.
  - k increments each cycle.
  - After the beat with k = N/P-1, go to HOLD.
- **HOLD**
  - out_valid = 1 and llr_out is stable.
  - When out_ready is high, go to IDLE.
- **f lane**
  - Result is bit-exact with the existing f unit: sign = sign(a) XOR sign(b), magnitude = min(|a|,|b|), with |x| taken over the low BITS-1 bits.
  - Inherited corners, kept as-is:
    - |−2^(BITS−1)| evaluates to 0.
    - A zero magnitude with differing signs yields the most-negative code (1 followed by zeros).
- **g lane** (when compiled in)
  - Computes b + a if u_i = 0, else b − a.
  - Internal width is BITS+1.
  - Result saturates to [−(2^(BITS−1)−1), +(2^(BITS−1)−1)].
- **Input handling**
  - in_valid is ignored outside IDLE.
  - Inputs are never consumed twice; in_ready falls the cycle after accept.
- **Output register** retains the last result after out_ready, until RUN overwrites it slot by slot.

## Timing
- **Reset (async, rst_n = 0):**
  - State = IDLE, k = 0, llr_out = 0, out_valid = 0, in_ready = 1 (after release).
  - Captured registers are cleared.
- **Latency:** accept on edge T; results are written on edges T+1..T+N/P; out_valid is high from T+N/P+1.
  - For N=16, P=4: 5 cycles from accept to out_valid.
- **Throughput:** one vector per N/P+2 cycles with out_ready held high (accept, N/P RUN beats, one HOLD/IDLE return).
- **Back-pressure:** while out_ready = 0, the block holds HOLD indefinitely and in_ready stays 0.
- **Reset mid-RUN or mid-HOLD:** the block aborts immediately. There is no partial output and out_valid drops asynchronously.
- **No combinational path** from in_valid to in_ready or from out_ready to out_valid; all handshake outputs are registered state decodes.
- **N = P:** RUN lasts exactly one beat.

## Configuration
- Macro: POLAR_FG_SCHED_G_EN.
- **Defined:**
  - g lanes are instantiated.
  - mode selects f or g.
  - u_in is captured.
- **Undefined:**
  - Only f lanes exist.
  - mode and u_in are ignored and not registered.
  - Results are always f.
  - Handshake and timing are identical to the defined build.

## Test plan
- **Reset:** assert rst_n = 0 mid-RUN (N=16, P=4, BITS=4). Required: out_valid = 0 and llr_out = 0 immediately; in_ready = 1 after release; no result is later produced for the aborted vector.
- **f basic:** mode = 0, a_i = 3, b_i = −5 for all i, out_ready = 1. Required: accept at cycle T, out_valid at T+5, every slot = −3 (4'b1101).
- **f corners:** a = 0, b = −3 gives 4'b1000; a = −8, b = 3 gives 4'b1000; a = −8, b = −3 gives 0; a = 7, b = 7 gives 7. All must match the f unit.
- **g saturate** (macro defined): mode = 1 with:
  - u = 0, a = 5, b = 4 gives +7.
  - u = 1, a = 6, b = −4 gives −7.
  - u = 1, a = 2, b = 5 gives 3.
- **Back-pressure:** hold out_ready = 0 for 10 cycles after out_valid while in_valid = 1. Required: in_ready = 0 throughout, llr_out stable. Raise out_ready: IDLE is reached next cycle, the second vector is accepted the following cycle, and results are correct.
- **Slot ordering:** ramp inputs a_i = i mod 8, b_i = 7. Required: f result in slot i = i mod 8, confirming the lane-to-slot mapping across all N/P beats.
